alu_scoreboard: RTL and testbench

Self-checking scoreboard that sits downstream of the ALU stimulus generator, beside the 8-bit ALU under test. Each cycle it samples the applied operands (R, S, CI, ALB_MI) and computes the expected ALU result. It delays that result by the DUT latency, compares it against the DUT outputs (F, CO), and keeps pass/error counts plus a capture of the first failing vector. Bench top-levels use it as the pass/fail authority.

---
 rtl/alu_scoreboard.sv | 159 +++++++++++++++
 tb/tb_alu_scoreboard.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scoreboard.sv
// alu_scoreboard: delayed reference-model checker for an 8-bit ALU.
// Define ALU_SB_SIGNATURE_EN to add the 16-bit MISR signature output.
module alu_scoreboard #(
   parameter int DUT_LAT     = 1,
   parameter int CNT_W       = 16,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       R,
   input  logic [7:0]       S,
   input  logic             CI,
   input  logic [1:0]       ALB_MI,
   input  logic [7:0]       F,
   input  logic             CO,
   output logic             mismatch,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [36:0]      first_err,
   output logic             busy,
   output logic             halted
`ifdef ALU_SB_SIGNATURE_EN
   ,
   output logic [15:0]      signature
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_HALT
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DUT_LAT-1:0] r_vld;
   logic [27:0]        r_dat [DUT_LAT];
   logic [8:0]         w_exp;
   logic [27:0]        w_last;
   logic               w_run;
   logic               w_cmp;
   logic               w_fail;
   logic               r_mm;
   logic [CNT_W-1:0]   r_pass;
   logic [CNT_W-1:0]   r_err;
   logic [36:0]        r_first;

   always_comb begin
      w_exp = 9'h000;
      case (ALB_MI)
         2'b00:   w_exp = {1'b0, R} + {1'b0, S} + {8'h00, CI};
         2'b01:   w_exp = {1'b0, R} + {1'b0, ~S} + {8'h00, CI};
         2'b10:   w_exp = {1'b0, R & S};
         default: w_exp = {1'b0, R ^ S};
      endcase
   end

   // entry layout: {ALB_MI, CI, R, S, expF, expCO}
   assign w_run  = (r_state != ST_HALT);
   assign w_last = r_dat[DUT_LAT-1];
   assign w_cmp  = w_run & r_vld[DUT_LAT-1];
   assign w_fail = w_cmp & (w_last[8:0] != {F, CO});

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= '0;
      end else if (w_run) begin
         r_vld[0] <= enable;
         for (int i = 1; i < DUT_LAT; i++)
            r_vld[i] <= r_vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (w_run) begin
         r_dat[0] <= {ALB_MI, CI, R, S, w_exp[7:0], w_exp[8]};
         for (int i = 1; i < DUT_LAT; i++)
            r_dat[i] <= r_dat[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mm    <= 1'b0;
         r_pass  <= '0;
         r_err   <= '0;
         r_first <= '0;
      end else begin
         r_mm <= w_fail;
         if (w_cmp && !w_fail && r_pass != '1)
            r_pass <= r_pass + CNT_W'(1);
         if (w_fail) begin
            if (r_err != '1)
               r_err <= r_err + CNT_W'(1);
            if (r_err == '0)
               r_first <= {w_last, F, CO};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (STOP_ON_ERR && w_fail) begin
         w_state_nxt = ST_HALT;
      end else begin
         case (r_state)
            ST_IDLE:
               if (enable) w_state_nxt = ST_RUN;
            ST_RUN:
               if (!enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN:
               if (enable)
                  w_state_nxt = ST_RUN;
               else if (r_vld == '0)
                  w_state_nxt = ST_IDLE;
            default:
               w_state_nxt = ST_HALT;
         endcase
      end
   end

   always_comb begin
      halted = (r_state == ST_HALT);
      busy   = |r_vld;
   end

   assign mismatch  = r_mm;
   assign pass_cnt  = r_pass;
   assign err_cnt   = r_err;
   assign first_err = r_first;

`ifdef ALU_SB_SIGNATURE_EN
   logic [15:0] r_sig;
   logic [15:0] w_fold;

   // CRC-16 style step, polynomial x^16+x^12+x^5+1
   assign w_fold = r_sig ^ {7'b0, CO, F};

   always_ff @(posedge clk) begin
      if (reset)
         r_sig <= 16'hFFFF;
      else if (w_cmp)
         r_sig <= {w_fold[14:0], 1'b0} ^
                  (w_fold[15] ? 16'h1021 : 16'h0000);
   end

   assign signature = r_sig;
`endif

endmodule

// File: tb/tb_alu_scoreboard.sv
// tb_alu_scoreboard: five scoreboard instances with different parameters,
// each fed by an ideal delayed ALU whose outputs can be corrupted.
module tb_alu_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] R = 8'h00;
   logic [7:0] S = 8'h00;
   logic       CI = 1'b0;
   logic [1:0] OP = 2'b00;
   logic [4:0] en = 5'h00;
   logic [4:0] rst = 5'h1f;
   logic [8:0] flt [5] = '{9'h0, 9'h0, 9'h0, 9'h0, 9'h0};
   logic       ovr_en = 1'b0;
   logic [8:0] ovr_v = 9'h0;
   logic [8:0] pipe [8];

   logic [4:0]  mm, bz, hl;
   logic [36:0] fe [5];
   logic [15:0] pc0, ec0, pc1, ec1, pc3, ec3, pc4, ec4;
   logic [3:0]  pc2, ec2;
   logic [8:0]  w_f0, w_f1, w_f2, w_f3, w_f4;
`ifdef ALU_SB_SIGNATURE_EN
   logic [15:0] sig [5];
`endif

   int n_run = 0;
   int n_fail = 0;
   int mmc [5] = '{0, 0, 0, 0, 0};

   typedef struct {
      int         due;
      logic [1:0] op;
      logic       ci;
      logic [7:0] r;
      logic [7:0] s;
   } vec_t;

   // returns {CO, F}
   function automatic logic [8:0] alu(input logic [1:0] op, input logic ci,
                                      input logic [7:0] r, input logic [7:0] s);
      int v;
      case (op)
         2'd0:    v = r + s + ci;
         2'd1:    v = r + (255 - s) + ci;
         2'd2:    v = r & s;
         default: v = r ^ s;
      endcase
      return v[8:0];
   endfunction

   always @(posedge clk) begin
      pipe[0] <= alu(OP, CI, R, S);
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
   end

   assign w_f0 = ovr_en ? ovr_v : (pipe[0] ^ flt[0]);
   assign w_f1 = pipe[0] ^ flt[1];
   assign w_f2 = pipe[0] ^ flt[2];
   assign w_f3 = pipe[3] ^ flt[3];
   assign w_f4 = pipe[2] ^ flt[4];

   always @(negedge clk)
      for (int k = 0; k < 5; k++) if (mm[k]) mmc[k]++;

   alu_scoreboard #(.DUT_LAT(1), .CNT_W(16), .STOP_ON_ERR(1'b0)) u0 (
      .clk(clk), .reset(rst[0]), .enable(en[0]), .R(R), .S(S), .CI(CI),
      .ALB_MI(OP), .F(w_f0[7:0]), .CO(w_f0[8]), .mismatch(mm[0]),
      .pass_cnt(pc0), .err_cnt(ec0), .first_err(fe[0]), .busy(bz[0]),
      .halted(hl[0])
`ifdef ALU_SB_SIGNATURE_EN
      , .signature(sig[0])
`endif
   );
   alu_scoreboard #(.DUT_LAT(1), .CNT_W(16), .STOP_ON_ERR(1'b1)) u1 (
      .clk(clk), .reset(rst[1]), .enable(en[1]), .R(R), .S(S), .CI(CI),
      .ALB_MI(OP), .F(w_f1[7:0]), .CO(w_f1[8]), .mismatch(mm[1]),
      .pass_cnt(pc1), .err_cnt(ec1), .first_err(fe[1]), .busy(bz[1]),
      .halted(hl[1])
`ifdef ALU_SB_SIGNATURE_EN
      , .signature(sig[1])
`endif
   );
   alu_scoreboard #(.DUT_LAT(1), .CNT_W(4), .STOP_ON_ERR(1'b0)) u2 (
      .clk(clk), .reset(rst[2]), .enable(en[2]), .R(R), .S(S), .CI(CI),
      .ALB_MI(OP), .F(w_f2[7:0]), .CO(w_f2[8]), .mismatch(mm[2]),
      .pass_cnt(pc2), .err_cnt(ec2), .first_err(fe[2]), .busy(bz[2]),
      .halted(hl[2])
`ifdef ALU_SB_SIGNATURE_EN
      , .signature(sig[2])
`endif
   );
   alu_scoreboard #(.DUT_LAT(4), .CNT_W(16), .STOP_ON_ERR(1'b0)) u3 (
      .clk(clk), .reset(rst[3]), .enable(en[3]), .R(R), .S(S), .CI(CI),
      .ALB_MI(OP), .F(w_f3[7:0]), .CO(w_f3[8]), .mismatch(mm[3]),
      .pass_cnt(pc3), .err_cnt(ec3), .first_err(fe[3]), .busy(bz[3]),
      .halted(hl[3])
`ifdef ALU_SB_SIGNATURE_EN
      , .signature(sig[3])
`endif
   );
   alu_scoreboard #(.DUT_LAT(3), .CNT_W(16), .STOP_ON_ERR(1'b0)) u4 (
      .clk(clk), .reset(rst[4]), .enable(en[4]), .R(R), .S(S), .CI(CI),
      .ALB_MI(OP), .F(w_f4[7:0]), .CO(w_f4[8]), .mismatch(mm[4]),
      .pass_cnt(pc4), .err_cnt(ec4), .first_err(fe[4]), .busy(bz[4]),
      .halted(hl[4])
`ifdef ALU_SB_SIGNATURE_EN
      , .signature(sig[4])
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_vec();
      R  = 8'($urandom);
      S  = 8'($urandom);
      CI = 1'($urandom);
      OP = 2'($urandom);
   endtask

   task automatic test_reset();
      rst = 5'h1f;
      en  = 5'h00;
      repeat (2) tick();
      rst = 5'h00;
      n_run++;
      if (pc0 !== 16'h0) begin
         n_fail++; $display("FAIL reset_pass got %0h want 0", pc0);
      end
      n_run++;
      if (ec0 !== 16'h0) begin
         n_fail++; $display("FAIL reset_err got %0h want 0", ec0);
      end
      n_run++;
      if (fe[0] !== 37'h0) begin
         n_fail++; $display("FAIL reset_first got %0h want 0", fe[0]);
      end
      n_run++;
      if ({mm, bz, hl} !== 15'h0) begin
         n_fail++; $display("FAIL reset_flags got %0h want 0", {mm, bz, hl});
      end
   endtask

   task automatic test_ops();
      logic [7:0] tr [4] = '{8'h55, 8'hAA, 8'h0F, 8'hFF};
      logic [7:0] ts [4] = '{8'h33, 8'h0F, 8'hF0, 8'h00};
      logic       tc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [8:0] lit [4] = '{9'h089, 9'h19A, 9'h000, 9'h0FF};
      int m0 = mmc[0];
      ovr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         en[0] = (i < 4);
         if (i < 4) begin
            R = tr[i]; S = ts[i]; CI = tc[i]; OP = 2'(i);
         end
         if (i > 0) ovr_v = lit[i-1];
         tick();
         if (i > 0) begin
            n_run++;
            if (pc0 !== 16'(i)) begin
               n_fail++; $display("FAIL ops_pass%0d got %0d want %0d", i, pc0, i);
            end
         end
      end
      ovr_en = 1'b0;
      n_run++;
      if (ec0 !== 16'h0 || mmc[0] != m0) begin
         n_fail++; $display("FAIL ops_err got %0d/%0d want 0/0", ec0, mmc[0] - m0);
      end
      tick();
      n_run++;
      if (bz[0] !== 1'b0) begin
         n_fail++; $display("FAIL ops_busy got %0b want 0", bz[0]);
      end
   endtask

   task automatic test_fault();
      logic [7:0] tr [4] = '{8'h55, 8'hAA, 8'h0F, 8'hFF};
      logic [7:0] ts [4] = '{8'h33, 8'h0F, 8'hF0, 8'h00};
      logic       tc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [36:0] want = {2'b10, 1'b1, 8'h0F, 8'hF0, 8'h00, 1'b0, 8'h01, 1'b0};
      rst[0] = 1'b1; tick(); rst[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         en[0] = (i < 4);
         if (i < 4) begin
            R = tr[i]; S = ts[i]; CI = tc[i]; OP = 2'(i);
         end
         flt[0] = (i == 3) ? 9'h001 : 9'h000;
         tick();
         if (i == 3) begin
            n_run++;
            if (mm[0] !== 1'b1 || ec0 !== 16'd1 || pc0 !== 16'd2) begin
               n_fail++;
               $display("FAIL fault_hit got mm=%0b err=%0d pass=%0d want 1/1/2", mm[0], ec0, pc0);
            end
            n_run++;
            if (fe[0] !== want) begin
               n_fail++; $display("FAIL fault_first got %0h want %0h", fe[0], want);
            end
         end
      end
      n_run++;
      if (mm[0] !== 1'b0 || ec0 !== 16'd1 || pc0 !== 16'd3) begin
         n_fail++;
         $display("FAIL fault_after got mm=%0b err=%0d pass=%0d want 0/1/3", mm[0], ec0, pc0);
      end
      flt[0] = 9'h0;
   endtask

   task automatic test_halt();
      int m1;
      rst[1] = 1'b1; tick(); rst[1] = 1'b0;
      m1 = mmc[1];
      flt[1] = 9'h001;
      en[1] = 1'b1;
      rnd_vec(); tick();
      n_run++;
      if (hl[1] !== 1'b0) begin
         n_fail++; $display("FAIL halt_early got %0b want 0", hl[1]);
      end
      rnd_vec(); tick();
      n_run++;
      if (hl[1] !== 1'b1 || ec1 !== 16'd1 || pc1 !== 16'd0) begin
         n_fail++;
         $display("FAIL halt_enter got h=%0b err=%0d pass=%0d want 1/1/0", hl[1], ec1, pc1);
      end
      repeat (20) begin
         rnd_vec(); tick();
      end
      n_run++;
      if (hl[1] !== 1'b1 || ec1 !== 16'd1 || pc1 !== 16'd0 || mmc[1] - m1 != 1) begin
         n_fail++;
         $display("FAIL halt_frozen got h=%0b err=%0d pass=%0d mm=%0d want 1/1/0/1",
                  hl[1], ec1, pc1, mmc[1] - m1);
      end
      en[1] = 1'b0;
   endtask

   task automatic test_saturate();
      int e;
      rst[2] = 1'b1; tick(); rst[2] = 1'b0;
      for (int i = 0; i <= 40; i++) begin
         en[2] = (i < 40);
         rnd_vec(); tick();
         e = (i > 15) ? 15 : i;
         n_run++;
         if (pc2 !== 4'(e)) begin
            n_fail++; $display("FAIL sat_pass%0d got %0d want %0d", i, pc2, e);
         end
      end
      n_run++;
      if (ec2 !== 4'h0) begin
         n_fail++; $display("FAIL sat_err got %0d want 0", ec2);
      end
   endtask

   task automatic test_reset_midrun();
      rst[3] = 1'b1; tick(); rst[3] = 1'b0;
      en[3] = 1'b1;
      repeat (3) begin
         rnd_vec(); tick();
      end
      en[3] = 1'b0;
      tick();
      n_run++;
      if (bz[3] !== 1'b1 || pc3 !== 16'd0) begin
         n_fail++; $display("FAIL mid_inflight got b=%0b pass=%0d want 1/0", bz[3], pc3);
      end
      rst[3] = 1'b1; tick(); rst[3] = 1'b0;
      n_run++;
      if (bz[3] !== 1'b0 || pc3 !== 16'd0 || ec3 !== 16'd0) begin
         n_fail++;
         $display("FAIL mid_reset got b=%0b pass=%0d err=%0d want 0/0/0", bz[3], pc3, ec3);
      end
      repeat (6) tick();
      n_run++;
      if (pc3 !== 16'd0 || ec3 !== 16'd0) begin
         n_fail++; $display("FAIL mid_after got pass=%0d err=%0d want 0/0", pc3, ec3);
      end
   endtask

   task automatic test_enable_pattern();
      logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      int   e;
      logic eb;
      rst[4] = 1'b1; tick(); rst[4] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         en[4] = (k < 4) ? pat[k] : 1'b0;
         rnd_vec(); tick();
         e  = 0;
         eb = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (pat[j] && j + 3 <= k) e++;
            if (pat[j] && j <= k && j >= k - 2) eb = 1'b1;
         end
         n_run++;
         if (pc4 !== 16'(e) || bz[4] !== eb) begin
            n_fail++;
            $display("FAIL pat_edge%0d got pass=%0d b=%0b want %0d/%0b", k, pc4, bz[4], e, eb);
         end
      end
      n_run++;
      if (ec4 !== 16'd0) begin
         n_fail++; $display("FAIL pat_err got %0d want 0", ec4);
      end
   endtask

   task automatic test_random();
      vec_t        q [$];
      vec_t        v;
      int          ep = 0;
      int          ee = 0;
      logic        em;
      logic [36:0] efe = '0;
      logic [8:0]  x, g;
      rst[0] = 1'b1; tick(); rst[0] = 1'b0;
      for (int k = 0; k < 300; k++) begin
         en[0] = ($urandom_range(0, 3) != 0);
         rnd_vec();
         flt[0] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(1, 511)) : 9'h0;
         em = 1'b0;
         if (q.size() > 0 && q[0].due == k) begin
            v = q.pop_front();
            x = alu(v.op, v.ci, v.r, v.s);
            g = x ^ flt[0];
            if (g == x) begin
               ep++;
            end else begin
               if (ee == 0) efe = {v.op, v.ci, v.r, v.s, x[7:0], x[8], g[7:0], g[8]};
               ee++;
               em = 1'b1;
            end
         end
         if (en[0]) q.push_back('{k + 1, OP, CI, R, S});
         tick();
         n_run++;
         if (pc0 !== 16'(ep) || ec0 !== 16'(ee) || mm[0] !== em) begin
            n_fail++;
            $display("FAIL rand%0d got p=%0d e=%0d m=%0b want %0d/%0d/%0b",
                     k, pc0, ec0, mm[0], ep, ee, em);
         end
      end
      en[0] = 1'b0;
      flt[0] = 9'h0;
      n_run++;
      if (fe[0] !== efe) begin
         n_fail++; $display("FAIL rand_first got %0h want %0h", fe[0], efe);
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_fault();
      test_halt();
      test_saturate();
      test_reset_midrun();
      test_enable_pattern();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
